// File: rtl/id_ex_operand_reg.sv
// id_ex_operand_reg: registered operand pair + mux select between decode and
// the EX-stage 2-input operand mux. Valid/ready handshake with a 2-entry skid
// buffer (main + skid) so in_ready comes straight from a flop, plus a
// synchronous flush for branch squash.
// Optional feature macro: STALL_COUNT_EN adds a saturating 16-bit stall counter.
module id_ex_operand_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_input1,
    input  logic [WIDTH-1:0] in_input2,
    input  logic             in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_input1,
    output logic [WIDTH-1:0] out_input2,
    output logic             out_op
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Payload layout: {op, input1, input2}
    localparam int PW = 2 * WIDTH + 1;

    logic          main_valid_reg;
    logic          skid_valid_reg;
    logic          ready_reg;
    logic [PW-1:0] main_data_reg;
    logic [PW-1:0] skid_data_reg;

    logic          main_valid_next;
    logic          skid_valid_next;
    logic          load_main_from_skid;
    logic          load_main_from_in;
    logic          load_skid;

    logic [PW-1:0] in_data;
    logic          accept;
    logic          pop;
    logic          main_free;

    assign in_data   = {in_op, in_input1, in_input2};
    assign accept    = in_valid & ready_reg;
    assign pop       = main_valid_reg & out_ready;
    // Main can take new data when it is empty or being consumed this cycle
    assign main_free = ~main_valid_reg | pop;

    // Next-state decision for the two entries; flush overrides everything
    always_comb begin
        main_valid_next     = main_valid_reg;
        skid_valid_next     = skid_valid_reg;
        load_main_from_skid = 1'b0;
        load_main_from_in   = 1'b0;
        load_skid           = 1'b0;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (main_free) begin
            if (skid_valid_reg) begin
                // in_ready is low here, so no accept can collide with this move
                load_main_from_skid = 1'b1;
                main_valid_next     = 1'b1;
                skid_valid_next     = 1'b0;
            end else if (accept) begin
                load_main_from_in = 1'b1;
                main_valid_next   = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    // Valid bits and the registered ready; ready mirrors the next skid state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= ~skid_valid_next;
        end
    end

    // Payload registers only move on a load; otherwise they keep the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            if (load_main_from_skid) begin
                main_data_reg <= skid_data_reg;
            end else if (load_main_from_in) begin
                main_data_reg <= in_data;
            end
            if (load_skid) begin
                skid_data_reg <= in_data;
            end
        end
    end

    assign in_ready   = ready_reg;
    assign out_valid  = main_valid_reg;
    assign out_op     = main_data_reg[PW-1];
    assign out_input1 = main_data_reg[2*WIDTH-1:WIDTH];
    assign out_input2 = main_data_reg[WIDTH-1:0];

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles where EX holds off a valid set; saturates, ignores flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'h0000;
        end else if (main_valid_reg && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// Self-checking bench for id_ex_operand_reg: a FIFO-of-depth-2 model compared
// every cycle, plus directed literal checks following the test plan.
module tb_id_ex_operand_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_input1;
    logic [W-1:0] in_input2;
    logic         in_op;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_input1;
    logic [W-1:0] out_input2;
    logic         out_op;
`ifdef STALL_COUNT_EN
    logic [15:0]  stall_cnt;
`endif

    id_ex_operand_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_input1  (in_input1),
        .in_input2  (in_input2),
        .in_op      (in_op),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_input1 (out_input1),
        .out_input2 (out_input2),
        .out_op     (out_op)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: pending sets as a queue of {op, input1, input2}; capacity 2
    logic [2*W:0]  m_q[$];
    logic [2*W:0]  m_last;
    logic          m_ready;
    int            m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = '0;
        m_ready = 1'b0;
        m_stall = 0;
    endtask

    // One clock edge of the model, using inputs as the DUT sees them
    task automatic model_edge();
        bit acc;
        bit pp;
        acc = in_valid && m_ready;
        pp  = (m_q.size() > 0) && out_ready;
        if ((m_q.size() > 0) && !out_ready && m_stall < 65535) m_stall++;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back({in_op, in_input1, in_input2});
        end
        if (m_q.size() > 0) m_last = m_q[0];
        m_ready = (m_q.size() < 2);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        in_valid  = v;
        in_input1 = a;
        in_input2 = b;
        in_op     = op;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic op);
        chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, ".in1"}, {24'd0, out_input1}, {24'd0, a});
        chk({name, ".in2"}, {24'd0, out_input2}, {24'd0, b});
        chk({name, ".op"}, {31'd0, out_op}, {31'd0, op});
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m.valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
            chk("m.ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("m.data", {15'd0, out_op, out_input1, out_input2}, {15'd0, m_last});
`ifdef STALL_COUNT_EN
            chk("m.stall", {16'd0, stall_cnt}, m_stall);
`endif
            $display("cyc t=%0t ov=%0b or=%0b ir=%0b out={%0h,%0h,%0b}", $time, out_valid,
                     out_ready, in_ready, out_input1, out_input2, out_op);
        end
    end

    logic [2*W:0] vec[4];

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        send(1'b0, 8'h00, 8'h00, 1'b0);
        model_reset();

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_out("t1.reset", 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        chk("t1.in_ready", {31'd0, in_ready}, 32'd1);

        // 2. single transfer
        out_ready = 1'b1;
        send(1'b1, 8'hA5, 8'h5A, 1'b0);
        step();
        send(1'b0, 8'h00, 8'h00, 1'b0);
        chk_out("t2.out", 1'b1, 8'hA5, 8'h5A, 1'b0);
        step();
        chk("t2.bubble", {31'd0, out_valid}, 32'd0);

        // 3. back-to-back streaming
        vec[0] = {1'b0, 8'hFF, 8'h00};
        vec[1] = {1'b1, 8'hFF, 8'h00};
        vec[2] = {1'b0, 8'h12, 8'h34};
        vec[3] = {1'b1, 8'hDE, 8'hBE};
        for (int i = 0; i < 4; i++) begin
            send(1'b1, vec[i][15:8], vec[i][7:0], vec[i][16]);
            step();
            chk_out($sformatf("t3.v%0d", i), 1'b1, vec[i][15:8], vec[i][7:0], vec[i][16]);
            chk($sformatf("t3.ready%0d", i), {31'd0, in_ready}, 32'd1);
        end
        send(1'b0, 8'h00, 8'h00, 1'b0);
        step();

        // 4. stall and skid fill
        out_ready = 1'b0;
        send(1'b1, 8'h12, 8'h34, 1'b1);
        step();
        send(1'b1, 8'hDE, 8'hBE, 1'b0);
        step();
        send(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t4.ready_low", {31'd0, in_ready}, 32'd0);
        chk_out("t4.held", 1'b1, 8'h12, 8'h34, 1'b1);
        step();
        chk_out("t4.held2", 1'b1, 8'h12, 8'h34, 1'b1);
        out_ready = 1'b1;
        step();
        chk_out("t4.pop2", 1'b1, 8'hDE, 8'hBE, 1'b0);
        chk("t4.ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("t4.empty", {31'd0, out_valid}, 32'd0);

        // 5. flush with both entries full
        out_ready = 1'b0;
        send(1'b1, 8'h11, 8'h22, 1'b0);
        step();
        send(1'b1, 8'h33, 8'h44, 1'b1);
        step();
        flush = 1'b1;
        send(1'b1, 8'hA5, 8'h5A, 1'b0);
        step();
        flush = 1'b0;
        send(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t5.valid", {31'd0, out_valid}, 32'd0);
        chk("t5.ready", {31'd0, in_ready}, 32'd1);
        chk("t5.payload_hold", {24'd0, out_input1}, 32'h11);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("t5.no_a5", {31'd0, out_valid}, 32'd0);
        end

        // 6. async reset mid-stall (fresh counter first)
        #2;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        send(1'b1, 8'h12, 8'h34, 1'b1);
        step();
        send(1'b1, 8'hDE, 8'hBE, 1'b0);
        step();
        send(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) step();
        chk("t6.full", {31'd0, in_ready}, 32'd0);
`ifdef STALL_COUNT_EN
        chk("t6.stall5", {16'd0, stall_cnt}, 32'd5);
`endif
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("t6.async", 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef STALL_COUNT_EN
        chk("t6.stall0", {16'd0, stall_cnt}, 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        step();
        chk("t6.ready_after", {31'd0, in_ready}, 32'd1);
        chk("t6.valid_after", {31'd0, out_valid}, 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_reg.md
Name: id_ex_operand_reg

Overview:
Pipeline register between the decode/forwarding logic and the EX-stage 2-input operand mux. It captures a pair of operands and the mux select, then presents them to the mux as registered, stable inputs. It uses a valid/ready handshake with a 2-entry skid buffer, so the upstream ready path is fully registered. A synchronous flush supports branch squash.

Parameters:
WIDTH, 8, operand width in bits; must match the downstream mux width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a valid operand set
in_ready  output  1  block can accept an operand set this cycle
in_input1  input  WIDTH  operand routed to mux input1
in_input2  input  WIDTH  operand routed to mux input2
in_op  input  1  mux select (0 selects input1, 1 selects input2)
flush  input  1  synchronous squash of all held entries
out_valid  output  1  out_* fields hold a valid operand set
out_ready  input  1  EX stage consumes the set this cycle
out_input1  output  WIDTH  registered operand 1, drives mux input1
out_input2  output  WIDTH  registered operand 2, drives mux input2
out_op  output  1  registered select, drives mux op

Behaviour:
- Storage: main entry (drives out_*), skid entry, one valid bit each. Entry payload is {op, input1, input2}, 2*WIDTH+1 bits.
- Reset (rst_n low, asynchronous): both valid bits 0, all payload registers 0. Hence out_valid=0, out_input1=0, out_input2=0, out_op=0. in_ready=1 from the first clk edge after release.
- in_ready = ~skid_valid, taken directly from a flop; no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: an accepted set appears on out_* the next cycle when main is empty or popping.
- Next-state priority, highest first:
  1. flush=1: both valid bits cleared next cycle. Any set accepted in the same cycle is discarded. Payload registers hold their values.
  2. Main empty or Pop, with skid valid: main loads from skid and skid clears. An Accept in the same cycle cannot occur, because in_ready=0.
  3. Main empty or Pop, with skid empty and Accept: main loads the input.
  4. Main empty or Pop, with no Accept and no skid: main valid clears (bubble).
  5. Main valid, no Pop, Accept: input goes to skid (skid becomes full, in_ready drops next cycle).
  6. Otherwise: hold.
- Stall behaviour: while out_valid=1 and out_ready=0, out_* are held bit-stable every cycle.
- When a valid bit is 0, payload registers hold their last value. Only out_valid qualifies the data.
- Ordering: strict FIFO; no set is duplicated or dropped except by flush.
- Full throughput: with in_valid=1 and out_ready=1 continuously, one set passes per cycle and skid stays empty.
- Reset asserted mid-transfer clears both entries immediately, regardless of clk.

Optional Feature:
Macro: STALL_COUNT_EN
- Defined: adds output stall_cnt [15:0].
  - Increments once per cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared only by rst_n; not affected by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, then high. Required: out_valid=0, out_input1=8'h00, out_input2=8'h00, out_op=0; in_ready=1 one cycle after release.
2. Single transfer, out_ready=1: send {A5, 5A, op=0}. Required: next cycle out_valid=1, out_input1=A5, out_input2=5A, out_op=0. Following cycle out_valid=0.
3. Back-to-back streaming, out_ready=1: send {FF,00,0}, {FF,00,1}, {12,34,0}, {DE,BE,1} on consecutive cycles. Required: outputs emerge in order on consecutive cycles, in_ready stays 1.
4. Stall and skid fill:
   - Hold out_ready=0 and send {12,34,1}, then {DE,BE,0}. Required: in_ready=0 on the next cycle and out_* stay {12,34,1}.
   - Raise out_ready. Required: {12,34,1} pops, then {DE,BE,0}; in_ready returns to 1 one cycle after skid drains.
5. Flush with both entries full: assert flush together with in_valid={A5,5A,0}. Required: next cycle out_valid=0 and in_ready=1; {A5,5A,0} never appears on the output.
6. Asynchronous reset mid-stall: with both entries full, pull rst_n low between clk edges. Required: out_valid=0 and out_* = 0 immediately. With STALL_COUNT_EN defined, also stall_cnt=0; before the reset, 5 stalled cycles must read stall_cnt=5.
